// File: rtl/fifo_pkg.sv
// Constants shared by the synchronous FIFO and the stream reader that drains it.
package fifo_pkg;

    localparam int FIFO_RD_LATENCY    = 1;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage : fifo_pkg

// File: rtl/fifo_stream_reader_hold_buf.sv
// Circular holding buffer for the stream reader: push at tail, pop at head,
// head word presented combinationally (zero while empty).
module stream_hold_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3,
    localparam int PW        = $clog2(BUF_DEPTH),
    localparam int OW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [OW-1:0]         o_occ,
    output logic [DATA_WIDTH-1:0] o_head
);

    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_occ;
    logic                  w_pop;

    // The caller never pushes into a full buffer; its issue rule reserves the slot.
    assign w_pop = i_pop & (r_occ != '0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;

endmodule : stream_hold_buf

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: pops words while non-empty and
// re-presents them on a valid/ready stream at up to one word per cycle.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUF_DEPTH  = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic                  busy
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [OW-1:0]        w_occ;
    logic [OW:0]          w_reserved;
    logic                 w_accept;

    // Stream handshake: a word transfers on any cycle with m_valid & m_ready;
    // once m_valid rises, m_data holds until that transfer happens.
    assign w_accept = m_valid & m_ready;

    // Issue decision never looks at m_ready: buffered plus in-flight words
    // must leave a free slot for the word this read will return.
    assign w_reserved = {1'b0, w_occ} + {{OW{1'b0}}, r_inflight};
    assign fifo_rd_en = rstn & en & ~fifo_empty & (w_reserved < (OW+1)'(BUF_DEPTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_accept) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    stream_hold_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_hold_buf (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_push      (r_inflight),
        .i_push_data (fifo_data),
        .i_pop       (w_accept),
        .o_occ       (w_occ),
        .o_head      (m_data)
    );

    assign m_valid  = (w_occ != '0);
    assign word_cnt = r_word_cnt;
    assign busy     = r_inflight | m_valid;

endmodule : fifo_stream_reader

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural 8-deep FIFO feeding the reader,
// scoreboard of written words checked in order at the stream output.
module tb_fifo_stream_reader;

    localparam int DW         = 8;
    localparam int BD         = 3;
    localparam int CW         = 16;
    localparam int FIFO_DEPTH = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [CW-1:0] word_cnt;
    logic          busy;
    logic          fifo_rd_en_n;
    logic          m_valid_n;
    logic [DW-1:0] m_data_n;
    logic [3:0]    word_cnt_n;
    logic          busy_n;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int            wr_total = 0;
    int            rd_total = 0;
    int            checks = 0;
    int            failures = 0;
    int            outst = 0;
    int            reads_seen = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          t4_done = 1'b0;

    assign fifo_empty = (wr_total == rd_total);

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .word_cnt(word_cnt), .busy(busy)
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .CNT_WIDTH(4)) u_dut_w4 (
        .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_n),
        .fifo_data(fifo_data), .m_valid(m_valid_n), .m_ready(m_ready), .m_data(m_data_n),
        .word_cnt(word_cnt_n), .busy(busy_n)
    );

    // Behavioural FIFO: registered read data, one cycle after the read strobe.
    always @(posedge clk) begin
        if (!rstn) begin
            fifo_q.delete();
            rd_total <= wr_total;
        end else if (fifo_rd_en && fifo_q.size() != 0) begin
            fifo_data <= fifo_q.pop_front();
            rd_total  <= rd_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: in-order scoreboard plus black-box occupancy / hold / busy rules.
    always @(negedge clk) begin
        if (!rstn) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                check("rd_en_while_empty", 32'(fifo_empty), 0);
                reads_seen++;
            end
            check("outstanding_le_depth", 32'(outst <= BD), 1);
            check("busy_vs_outstanding", 32'(busy), 32'(outst != 0));
            if (prev_stall) check("held_word", {m_valid, m_data}, {1'b1, prev_data});
            if (!m_valid) check("idle_data_zero", 32'(m_data), 0);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0d expected=none at %0t", m_data, $time);
                end else begin
                    check("order", 32'(m_data), 32'(exp_q.pop_front()));
                end
            end
            outst      = outst + int'(fifo_rd_en) - int'(m_valid && m_ready);
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic write_word(input logic [DW-1:0] v);
        int guard = 0;
        while ((wr_total - rd_total) >= FIFO_DEPTH && guard < 1000) begin
            tick();
            guard++;
        end
        if (guard >= 1000) check("fifo_space_timeout", 1, 0);
        fifo_q.push_back(v);
        wr_total++;
        exp_q.push_back(v);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) check("drain_timeout", 1, 0);
    endtask

    task automatic apply_reset();
        tick();
        rstn = 1'b0;
        #1;
        check("rst_fifo_rd_en", 32'(fifo_rd_en), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", 32'(m_data), 0);
        check("rst_word_cnt", 32'(word_cnt), 0);
        check("rst_word_cnt_w4", 32'(word_cnt_n), 0);
        check("rst_busy", 32'(busy), 0);
        exp_q.delete();
        repeat (3) tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int r0;
        int n;
        logic [DW-1:0] base;

        apply_reset();

        // T2: preloaded words stream out back-to-back
        m_ready = 1'b1;
        en      = 1'b0;
        for (int v = 22; v <= 29; v++) write_word(DW'(v));
        tick();
        en = 1'b1;
        g  = 0;
        while (!m_valid && g < 20) begin tick(); g++; end
        for (int i = 0; i < 8; i++) begin
            check("t2_consecutive_valid", 32'(m_valid), 1);
            tick();
        end
        wait_drain();
        check("t2_word_cnt", 32'(word_cnt), 8);
        check("t2_busy_idle", 32'(busy), 0);

        // T3: consumer stalled, reads stop once the buffer is reserved
        m_ready = 1'b0;
        r0      = reads_seen;
        for (int v = 22; v <= 29; v++) write_word(DW'(v));
        repeat (15) tick();
        check("t3_reads_issued", 32'(reads_seen - r0), 3);
        check("t3_m_valid", 32'(m_valid), 1);
        check("t3_m_data_head", 32'(m_data), 22);
        check("t3_fifo_left", 32'(wr_total - rd_total), 5);
        m_ready = 1'b1;
        wait_drain();
        check("t3_word_cnt", 32'(word_cnt), 16);

        // T1: reset in the middle of a stalled stream
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_word(DW'($urandom_range(0, 255)));
        repeat (3) tick();
        apply_reset();

        // T4: 100 words under alternating then random back-pressure
        en      = 1'b1;
        t4_done = 1'b0;
        fork
            begin
                for (int v = 22; v <= 121; v++) write_word(DW'(v));
                t4_done = 1'b1;
            end
            begin
                int k = 0;
                while (!t4_done) begin
                    m_ready = (k < 50) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
                    tick();
                    k++;
                end
            end
        join
        m_ready = 1'b1;
        wait_drain();
        check("t4_word_cnt", 32'(word_cnt), 100);
        check("t4_word_cnt_w4", 32'(word_cnt_n), 100 % 16);

        // T5: en dropped after exactly four reads
        en      = 1'b0;
        m_ready = 1'b1;
        base    = DW'($urandom_range(0, 200));
        for (int i = 0; i < 8; i++) write_word(base + DW'(i));
        tick();
        en = 1'b1;
        n  = 0;
        g  = 0;
        while (n < 4 && g < 50) begin
            @(negedge clk);
            if (fifo_rd_en) n++;
            g++;
        end
        @(posedge clk);
        #1;
        en = 1'b0;
        g  = 0;
        while (busy && g < 50) begin tick(); g++; end
        tick();
        check("t5_busy_after_stop", 32'(busy), 0);
        check("t5_delivered", 32'(word_cnt), 104);
        check("t5_fifo_left", 32'(wr_total - rd_total), 4);
        en = 1'b1;
        wait_drain();
        check("t5_word_cnt_resumed", 32'(word_cnt), 108);

        // T6: narrow counter wraps after 17 accepted words
        apply_reset();
        en      = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) write_word(DW'($urandom_range(0, 255)));
        wait_drain();
        check("t6_word_cnt", 32'(word_cnt), 17);
        check("t6_word_cnt_w4_wrap", 32'(word_cnt_n), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_stream_reader
